// File: rtl/rvb_crc_pkg.sv
// Shared constants and types for the multi-cycle CRC32/CRC32C unit.
package rvb_crc_pkg;

    localparam logic [31:0] CRC32_POLY  = 32'hEDB8_8320;
    localparam logic [31:0] CRC32C_POLY = 32'h82F6_3B78;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rvb_crc_step.sv
// Combinational fold of STEP consecutive reflected CRC shift steps.
module rvb_crc_step #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned STEP = 8
) (
    input  logic [XLEN-1:0] x_i,
    input  logic [XLEN-1:0] poly_i,
    output logic [XLEN-1:0] x_o
);

    logic [XLEN-1:0] acc;

    always_comb begin
        acc = x_i;
        for (int i = 0; i < int'(STEP); i++) begin
            acc = (acc >> 1) ^ (poly_i & {XLEN{acc[0]}});
        end
        x_o = acc;
    end

endmodule

// File: rtl/rvb_crc_seq.sv
// Multi-cycle CRC32/CRC32C for crc32[c].{b,h,w,d} with valid/ready handshake
// and back-to-back issue from the DONE state.
module rvb_crc_seq
    import rvb_crc_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned STEP = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            din_valid,
    output logic            din_ready,
    input  logic [XLEN-1:0] din_rs1,
    input  logic            din_insn20,
    input  logic            din_insn21,
    input  logic            din_insn23,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic [XLEN-1:0] dout_rd
);

    localparam int unsigned CNT_W = $clog2(64 / STEP) + 1;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   x_q;
    logic [XLEN-1:0]   poly_q;
    logic              valid_q;

    logic              accept;
    logic [1:0]        size_eff;
    logic [CNT_W-1:0]  cnt_load;
    logic [XLEN-1:0]   poly_sel;
    logic [XLEN-1:0]   x_fold;

    // Request decode: a doubleword op on a 32-bit core runs as a word op.
    always_comb begin
        size_eff = {din_insn21, din_insn20};
        if (XLEN == 32 && size_eff == SZ_D) begin
            size_eff = SZ_W;
        end
        cnt_load = CNT_W'((32'd8 << size_eff) / STEP);
        poly_sel = din_insn23 ? XLEN'(CRC32C_POLY) : XLEN'(CRC32_POLY);
    end

    assign din_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & dout_ready);
    assign accept    = din_valid & din_ready;

    rvb_crc_step #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_step (
        .x_i    (x_q),
        .poly_i (poly_q),
        .x_o    (x_fold)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            poly_q  <= '0;
            valid_q <= 1'b0;
        end else if (accept) begin
            state_q <= ST_BUSY;
            cnt_q   <= cnt_load;
            x_q     <= din_rs1;
            poly_q  <= poly_sel;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BUSY: begin
                    x_q   <= x_fold;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_DONE;
                        valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (dout_ready) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dout_valid = valid_q;
    assign dout_rd    = x_q;

endmodule

// File: tb/tb_rvb_crc_seq.sv
// Directed and randomised checks of rvb_crc_seq on a 64-bit/STEP=8 and a 32-bit/STEP=1 instance.
module tb_rvb_crc_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_din_valid, a_din_ready, a_c, a_dout_valid, a_dout_ready;
    logic [1:0]  a_sz;
    logic [63:0] a_din_rs1, a_dout_rd;

    logic        b_din_valid, b_din_ready, b_c, b_dout_valid, b_dout_ready;
    logic [1:0]  b_sz;
    logic [31:0] b_din_rs1, b_dout_rd;

    int checks = 0;
    int errors = 0;

    rvb_crc_seq #(.XLEN(64), .STEP(8)) u_a (
        .clock      (clk),
        .reset      (rst),
        .din_valid  (a_din_valid),
        .din_ready  (a_din_ready),
        .din_rs1    (a_din_rs1),
        .din_insn20 (a_sz[0]),
        .din_insn21 (a_sz[1]),
        .din_insn23 (a_c),
        .dout_valid (a_dout_valid),
        .dout_ready (a_dout_ready),
        .dout_rd    (a_dout_rd)
    );

    rvb_crc_seq #(.XLEN(32), .STEP(1)) u_b (
        .clock      (clk),
        .reset      (rst),
        .din_valid  (b_din_valid),
        .din_ready  (b_din_ready),
        .din_rs1    (b_din_rs1),
        .din_insn20 (b_sz[0]),
        .din_insn21 (b_sz[1]),
        .din_insn23 (b_c),
        .dout_valid (b_dout_valid),
        .dout_ready (b_dout_ready),
        .dout_rd    (b_dout_rd)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference of the reflected CRC on an XLEN-wide register.
    function automatic logic [63:0] ref_crc(input logic [63:0] rs1, input logic [1:0] sz,
                                            input logic c, input int xlen);
        int          nbits;
        logic [63:0] x, poly, mask;
        mask  = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        nbits = (xlen == 32 && sz == 2'd3) ? 32 : (8 << sz);
        poly  = c ? 64'h82F6_3B78 : 64'hEDB8_8320;
        x     = rs1 & mask;
        for (int i = 0; i < nbits; i++) begin
            x = (x >> 1) ^ (x[0] ? poly : 64'h0);
        end
        return x;
    endfunction

    function automatic int lat_of(input logic [1:0] sz, input int xlen, input int step);
        int nbits;
        nbits = (xlen == 32 && sz == 2'd3) ? 32 : (8 << sz);
        return nbits / step;
    endfunction

    // Issue one op on instance A from IDLE, check latency/result, hold DONE for stall cycles.
    task automatic run_a(input string tag, input logic [63:0] rs1, input logic [1:0] sz,
                         input logic c, input logic [63:0] exp, input int stall);
        int          lat;
        logic [63:0] held;
        check({tag, ".rdy"}, 64'(a_din_ready), 64'd1);
        a_din_rs1 = rs1; a_sz = sz; a_c = c; a_din_valid = 1'b1;
        @(negedge clk);
        a_din_valid = 1'b0; a_din_rs1 = ~rs1; a_sz = ~sz; a_c = ~c;
        lat = 0;
        while (!a_dout_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, 64'(lat), 64'(lat_of(sz, 64, 8)));
        check({tag, ".rd"}, a_dout_rd, exp);
        held = a_dout_rd;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, ".hold_rd"}, a_dout_rd, held);
            check({tag, ".hold_rdy"}, 64'(a_din_ready), 64'd0);
        end
        a_dout_ready = 1'b1;
        @(negedge clk);
        a_dout_ready = 1'b0;
        check({tag, ".drain"}, 64'(a_dout_valid), 64'd0);
    endtask

    task automatic run_b(input string tag, input logic [31:0] rs1, input logic [1:0] sz,
                         input logic c, input logic [31:0] exp, input int stall);
        int          lat;
        logic [31:0] held;
        check({tag, ".rdy"}, 64'(b_din_ready), 64'd1);
        b_din_rs1 = rs1; b_sz = sz; b_c = c; b_din_valid = 1'b1;
        @(negedge clk);
        b_din_valid = 1'b0; b_din_rs1 = ~rs1; b_sz = ~sz; b_c = ~c;
        lat = 0;
        while (!b_dout_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, 64'(lat), 64'(lat_of(sz, 32, 1)));
        check({tag, ".rd"}, 64'(b_dout_rd), 64'(exp));
        held = b_dout_rd;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, ".hold_rd"}, 64'(b_dout_rd), 64'(held));
            check({tag, ".hold_rdy"}, 64'(b_din_ready), 64'd0);
        end
        b_dout_ready = 1'b1;
        @(negedge clk);
        b_dout_ready = 1'b0;
        check({tag, ".drain"}, 64'(b_dout_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        a_din_valid = 1'b0; a_din_rs1 = '0; a_sz = '0; a_c = 1'b0; a_dout_ready = 1'b0;
        b_din_valid = 1'b0; b_din_rs1 = '0; b_sz = '0; b_c = 1'b0; b_dout_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.a_valid", 64'(a_dout_valid), 64'd0);
        check("rst.a_ready", 64'(a_din_ready), 64'd1);
        check("rst.b_valid", 64'(b_dout_valid), 64'd0);
        check("rst.b_ready", 64'(b_din_ready), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // Known table values and zero operands on the 64-bit instance.
        run_a("a.crc32b_ff",   64'h0000_00FF, 2'd0, 1'b0, 64'h2D02_EF8D, 0);
        run_a("a.crc32cb_ff",  64'h0000_00FF, 2'd0, 1'b1, 64'hAD7D_5351, 0);
        run_a("a.crc32b_ff01", 64'hFFFF_FF01, 2'd0, 1'b0, 64'h77F8_CF69, 0);
        run_a("a.crc32cb_1",   64'h0000_0001, 2'd0, 1'b1, 64'hF26B_8303, 0);
        run_a("a.crc32d_0",    64'h0,         2'd3, 1'b0, 64'h0,         0);
        run_a("a.crc32ch_0",   64'h0,         2'd1, 1'b1, 64'h0,         0);
        run_a("a.upper_shift", 64'h1234_5678_0000_00FF, 2'd0, 1'b0, 64'h0012_3456_5502_EF8D, 0);
        run_a("a.backpress",   64'hCAFE_F00D_1234_5678, 2'd2, 1'b1,
              ref_crc(64'hCAFE_F00D_1234_5678, 2'd2, 1'b1, 64), 10);

        // Serial instance: latency nbits, and .d executing as .w.
        run_b("b.crc32b_ff",   32'h0000_00FF, 2'd0, 1'b0, 32'h2D02_EF8D, 0);
        run_b("b.crc32cb_1",   32'h0000_0001, 2'd0, 1'b1, 32'hF26B_8303, 0);
        run_b("b.crc32w",      32'hDEAD_BEEF, 2'd2, 1'b0,
              32'(ref_crc(64'hDEAD_BEEF, 2'd2, 1'b0, 32)), 0);
        run_b("b.crc32d_as_w", 32'hDEAD_BEEF, 2'd3, 1'b0,
              32'(ref_crc(64'hDEAD_BEEF, 2'd2, 1'b0, 32)), 0);

        // Back-to-back word ops: accept in DONE, result LAT cycles after that accepting edge.
        begin
            logic [63:0] v [4];
            logic [63:0] e [4];
            int          iss, res, cyc, last;
            bit          pend;
            for (int i = 0; i < 4; i++) begin
                v[i] = {$urandom, $urandom};
                e[i] = ref_crc(v[i], 2'd2, 1'b1, 64);
            end
            iss = 0; res = 0; cyc = 0; last = 0; pend = 1'b0;
            a_din_rs1 = v[0]; a_sz = 2'd2; a_c = 1'b1; a_din_valid = 1'b1; a_dout_ready = 1'b1;
            while (res < 4 && cyc < 200) begin
                if (pend) begin
                    iss++;
                    pend = 1'b0;
                    if (iss < 4) a_din_rs1 = v[iss];
                    else         a_din_valid = 1'b0;
                end
                if (a_dout_valid) begin
                    check("b2b.rd", a_dout_rd, e[res]);
                    check("b2b.rdy", 64'(a_din_ready), 64'd1);
                    if (res > 0) check("b2b.gap", 64'(cyc - last), 64'd5);
                    last = cyc;
                    res++;
                end
                if (a_din_ready && a_din_valid) pend = 1'b1;
                @(negedge clk);
                cyc++;
            end
            check("b2b.count", 64'(res), 64'd4);
            a_din_valid = 1'b0;
            a_dout_ready = 1'b0;
            @(negedge clk);
        end

        // Reset in the middle of a long serial op discards it.
        begin
            bit seen;
            b_din_rs1 = 32'h1357_9BDF; b_sz = 2'd2; b_c = 1'b0; b_din_valid = 1'b1;
            b_dout_ready = 1'b1;
            @(negedge clk);
            b_din_valid = 1'b0;
            repeat (5) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rstbusy.valid", 64'(b_dout_valid), 64'd0);
            check("rstbusy.ready", 64'(b_din_ready), 64'd1);
            seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                seen = seen | b_dout_valid;
            end
            check("rstbusy.no_stale", 64'(seen), 64'd0);
            b_dout_ready = 1'b0;
        end

        // Randomised regression against the reference model.
        for (int k = 0; k < 150; k++) begin
            logic [63:0] r;
            logic [1:0]  s;
            logic        c;
            r = {$urandom, $urandom};
            s = 2'($urandom_range(0, 3));
            c = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_a("a.rand", r, s, c, ref_crc(r, s, c, 64), int'($urandom_range(0, 3)));
        end
        for (int k = 0; k < 60; k++) begin
            logic [31:0] r;
            logic [1:0]  s;
            logic        c;
            r = $urandom;
            s = 2'($urandom_range(0, 3));
            c = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_b("b.rand", r, s, c, 32'(ref_crc(64'(r), s, c, 32)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
